// File: rtl/inst_loader.sv
// inst_loader: host byte stream -> big-endian 32-bit program words with trailing XOR checksum.
// Optional opcode screening of written words: INST_LOADER_OPCHECK_EN.
`default_nettype none

module inst_loader #(
  parameter int RAM_SIZE = 256,
  parameter int ADDR_W   = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              err,
  output logic [8:0]        word_count
);

  typedef enum logic [2:0] {IDLE, HDR, BYTES, WRITE, CHK, DONE, ERR} state_t;

  state_t            state, state_nx;
  logic [7:0]        n_q, n_nx;
  logic [31:0]       word_q, word_nx;
  logic [1:0]        idx_q, idx_nx;
  logic [7:0]        csum_q, csum_nx;
  logic [ADDR_W-1:0] addr_q, addr_nx;
  logic              mem_we_nx, cpu_hold_nx, done_nx, err_nx;
  logic [ADDR_W-1:0] mem_addr_nx;
  logic [31:0]       mem_wdata_nx;
  logic [8:0]        word_count_nx;
  logic [8:0]        wc_inc;
  logic [31:0]       word_asm;
  logic              fire;
  logic              illegal;

  assign in_ready = (state == HDR) || (state == BYTES) || (state == CHK);
  assign fire     = in_valid && in_ready;
  assign word_asm = {word_q[23:0], in_data};
  assign wc_inc   = word_count + 9'd1;

`ifdef INST_LOADER_OPCHECK_EN
  // super_group 0 with funct 6..15 is unimplemented MUL/DIV/reserved
  assign illegal = (word_asm[26:24] == 3'd0) && (word_asm[19:16] >= 4'd6);
`else
  assign illegal = 1'b0;
`endif

  always_comb begin
    state_nx      = state;
    n_nx          = n_q;
    word_nx       = word_q;
    idx_nx        = idx_q;
    csum_nx       = csum_q;
    addr_nx       = addr_q;
    mem_we_nx     = 1'b0;
    mem_addr_nx   = mem_addr;
    mem_wdata_nx  = mem_wdata;
    cpu_hold_nx   = cpu_hold;
    done_nx       = done;
    err_nx        = err;
    word_count_nx = word_count;

    unique case (state)
      IDLE, DONE, ERR: begin
        if (start) state_nx = HDR;
      end
      HDR: begin
        if (fire) begin
          n_nx    = in_data;
          csum_nx = csum_q ^ in_data;
          if (in_data == 8'd0) begin
            state_nx = CHK;
          end else if ({1'b0, in_data} > 9'(RAM_SIZE)) begin
            state_nx = ERR;
            err_nx   = 1'b1;
          end else begin
            state_nx = BYTES;
          end
        end
      end
      BYTES: begin
        if (fire) begin
          word_nx = word_asm;
          csum_nx = csum_q ^ in_data;
          idx_nx  = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            state_nx     = WRITE;
            mem_we_nx    = !illegal;
            mem_addr_nx  = addr_q;
            mem_wdata_nx = word_asm;
          end
        end
      end
      WRITE: begin
`ifdef INST_LOADER_OPCHECK_EN
        if (!mem_we) begin
          state_nx = ERR;
          err_nx   = 1'b1;
        end else
`endif
        begin
          addr_nx       = addr_q + 1'b1;
          word_count_nx = wc_inc;
          state_nx      = (wc_inc == {1'b0, n_q}) ? CHK : BYTES;
        end
      end
      CHK: begin
        if (fire) begin
          if (in_data == csum_q) begin
            state_nx    = DONE;
            done_nx     = 1'b1;
            cpu_hold_nx = 1'b0;
          end else begin
            state_nx = ERR;
            err_nx   = 1'b1;
          end
        end
      end
      default: state_nx = IDLE;
    endcase

    // every session starts from a clean slate, whichever idle state it left
    if (state_nx == HDR && state != HDR) begin
      word_count_nx = 9'd0;
      addr_nx       = '0;
      csum_nx       = 8'd0;
      idx_nx        = 2'd0;
      done_nx       = 1'b0;
      err_nx        = 1'b0;
      cpu_hold_nx   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      n_q        <= 8'd0;
      word_q     <= 32'd0;
      idx_q      <= 2'd0;
      csum_q     <= 8'd0;
      addr_q     <= '0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= 32'd0;
      cpu_hold   <= 1'b1;
      done       <= 1'b0;
      err        <= 1'b0;
      word_count <= 9'd0;
    end else begin
      state      <= state_nx;
      n_q        <= n_nx;
      word_q     <= word_nx;
      idx_q      <= idx_nx;
      csum_q     <= csum_nx;
      addr_q     <= addr_nx;
      mem_we     <= mem_we_nx;
      mem_addr   <= mem_addr_nx;
      mem_wdata  <= mem_wdata_nx;
      cpu_hold   <= cpu_hold_nx;
      done       <= done_nx;
      err        <= err_nx;
      word_count <= word_count_nx;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_inst_loader.sv
// tb_inst_loader: directed checks of inst_loader load sessions, checksum, reset and opcode screening.
`default_nettype none

module tb_inst_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'd0;
  logic        in_ready, mem_we, cpu_hold, done, err;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [8:0]  word_count;

  int n_cmp = 0;
  int n_err = 0;
  int we_count = 0;
  int base = 0;
  logic [7:0]  log_addr [32];
  logic [31:0] log_data [32];

  inst_loader #(.RAM_SIZE(256), .ADDR_W(8)) dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_hold(cpu_hold), .done(done), .err(err), .word_count(word_count)
  );

  always #5 clk = ~clk;

  // write strobe lasts a full cycle, so the falling edge sees every pulse once
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      if (we_count < 32) begin
        log_addr[we_count] = mem_addr;
        log_data[we_count] = mem_wdata;
      end
      we_count++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic send(input logic [7:0] b);
    int t;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    t = 0;
    while (in_ready !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) begin
      n_cmp++;
      n_err++;
      $error("FAIL send_timeout observed=in_ready_low expected=in_ready_high");
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic gap();
    @(posedge clk); #1;
  endtask

  initial begin
    // 1: reset state, no stimulus
    #23;
    check("rst_hold", cpu_hold, 1);
    check("rst_ready", in_ready, 0);
    check("rst_wdata", mem_wdata, 0);
    @(negedge clk); reset = 1'b1;
    repeat (5) @(negedge clk);
    check("idle_hold", cpu_hold, 1);
    check("idle_done", done, 0);
    check("idle_err", err, 0);
    check("idle_ready", in_ready, 0);
    check("idle_addr", mem_addr, 0);
    check("idle_wc", word_count, 0);
    check("idle_nowe", we_count, 0);

    // 2: single-word load
    base = we_count;
    pulse_start();
    check("hdr_ready", in_ready, 1);
    send(8'h01); send(8'h00); send(8'h04); send(8'h05); send(8'h0A);
    check("t2_we_lat", mem_we, 1);
    check("t2_addr", mem_addr, 0);
    check("t2_wdata", mem_wdata, 32'h0004050A);
    send(8'h0A);
    check("t2_done", done, 1);
    check("t2_hold", cpu_hold, 0);
    check("t2_err", err, 0);
    check("t2_wc", word_count, 1);
    check("t2_nwrites", we_count - base, 1);

    // 3: two words with in_valid gaps; checksum 02^04^01^02 = 05
    base = we_count;
    pulse_start();
    check("t3_hold_start", cpu_hold, 1);
    check("t3_done_clr", done, 0);
    send(8'h02); gap();
    send(8'h00); gap(); send(8'h04); gap(); send(8'h01); gap(); send(8'h00); gap();
    send(8'h00); gap(); send(8'h02); gap(); send(8'h00); gap(); send(8'h00); gap();
    send(8'h05);
    check("t3_done", done, 1);
    check("t3_wc", word_count, 2);
    check("t3_nwrites", we_count - base, 2);
    check("t3_addr0", log_addr[base], 0);
    check("t3_data0", log_data[base], 32'h00040100);
    check("t3_addr1", log_addr[base+1], 1);
    check("t3_data1", log_data[base+1], 32'h00020000);

    // 4: bad checksum, then recovery
    base = we_count;
    pulse_start();
    send(8'h01); send(8'h00); send(8'h04); send(8'h05); send(8'h0A);
    send(8'h0B);
    check("t4_err", err, 1);
    check("t4_done", done, 0);
    check("t4_hold", cpu_hold, 1);
    check("t4_nwrites", we_count - base, 1);
    pulse_start();
    check("t4_err_clr", err, 0);
    send(8'h01); send(8'h00); send(8'h04); send(8'h05); send(8'h0A);
    send(8'h0A);
    check("t4_done", done, 1);
    check("t4_err2", err, 0);

    // 5: async reset mid-word, then empty load
    base = we_count;
    pulse_start();
    send(8'h01); send(8'h00); send(8'h04);
    #3 reset = 1'b0;
    #1;
    check("t5_ready", in_ready, 0);
    check("t5_hold", cpu_hold, 1);
    check("t5_wc", word_count, 0);
    check("t5_we", mem_we, 0);
    @(negedge clk); reset = 1'b1;
    repeat (3) @(negedge clk);
    check("t5_nowe", we_count - base, 0);
    pulse_start();
    send(8'h00); send(8'h00);
    check("t5_done", done, 1);
    check("t5_wc0", word_count, 0);
    check("t5_err", err, 0);

    // 6: word 0x00060000 (MUL/DIV group, funct 6)
    base = we_count;
    pulse_start();
    send(8'h01); send(8'h00); send(8'h06); send(8'h00); send(8'h00);
`ifdef INST_LOADER_OPCHECK_EN
    check("t6_no_we", mem_we, 0);
    repeat (2) @(negedge clk);
    check("t6_err", err, 1);
    check("t6_wc", word_count, 0);
    check("t6_nwrites", we_count - base, 0);
    check("t6_hold", cpu_hold, 1);
`else
    check("t6_we", mem_we, 1);
    check("t6_wdata", mem_wdata, 32'h00060000);
    send(8'h07);
    check("t6_done", done, 1);
    check("t6_wc", word_count, 1);
    check("t6_nwrites", we_count - base, 1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=running expected=finished");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
